logit_packer: RTL

LOGIT_PACKER -- requirements
Module: logit_packer

---
 rtl/logit_packer.sv | 113 +++++++++++
 1 files changed

// File: rtl/logit_packer.sv
// logit_packer: gathers NUM_CLASSES fp32 logits from the FC output stream
// into one packed frame and hands it to the argmax stage with valid/ready.
// A frame completes when its NUM_CLASSES-th logit is accepted. An early
// in_last abandons the frame, and a missing in_last on the final logit is
// still delivered. Both cases raise a one-cycle frame_err.
module logit_packer #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [NUM_CLASSES*DATA_WIDTH-1:0] out_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              frame_err,
  output logic [15:0]                       frame_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              idx;
  logic [DATA_WIDTH-1:0]   slots [NUM_CLASSES];

  logic in_fire;
  logic out_fire;
  logic at_last;
  logic short_frame;
  logic frame_done;
  logic slot_wr;

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign at_last     = (idx == LAST_IDX);
  assign short_frame = in_fire & in_last & ~at_last;
  assign frame_done  = in_fire & at_last;
  assign slot_wr     = in_fire & ~short_frame;

  // State register: FILL collects logits, HOLD presents the finished frame.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state: leave FILL on the last slot, leave HOLD on consumer accept.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (frame_done) state_nxt = HOLD;
      HOLD:    if (out_fire)   state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs follow the state. Both are held low during reset so
  // nothing is accepted or offered before the first post-reset cycle.
  always_comb begin
    in_ready  = (state == FILL) & ~rst;
    out_valid = (state == HOLD) & ~rst;
  end

  // Slot index: advances per stored logit, returns to 0 at end or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (in_fire) begin
      if (at_last || in_last) idx <= '0;
      else                    idx <= idx + 4'd1;
    end
  end

  // Slot storage: written in FILL only, so the frame stays frozen in HOLD.
  // Slots are never cleared between frames because the next complete frame
  // overwrites every one of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) slots[k] <= '0;
    end else if (slot_wr) begin
      slots[idx] <= in_data;
    end
  end

  // Pack slot k into bits [DATA_WIDTH*k +: DATA_WIDTH] of the output bus.
  always_comb begin
    out_vec = '0;
    for (int k = 0; k < NUM_CLASSES; k++)
      out_vec[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
  end

  // Framing error: registered pulse the cycle after a short frame, or after
  // a full frame whose final logit did not carry in_last.
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= short_frame | (frame_done & ~in_last);
  end

  // Delivered-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)           frame_cnt <= '0;
    else if (out_fire) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule
